regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Sequential reader for the 32x32 register file's read port: on a start pulse, walks x0..x(NREGS-1).
//  Drives the read address, captures the read data and streams each (index, value) beat out.
//  Output handshake is valid/ready. Used for debug/scan dump of architectural state.
//  Sits beside the core: shares a register-file read port (radd1/rdata1 path) via top-level mux.
// PARAMETERS
//  NREGS  32  number of registers walked (indices 0..NREGS-1)
//  AW     5   register address width (2**AW >= NREGS)
//  DW     32  register data width
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   synchronous, active-high reset
//  start         in   1   1-cycle request to begin a dump (ignored while busy)
//  rf_radd       out  AW  read address to register file
//  rf_rdata      in   DW  combinational read data for rf_radd (same cycle)
//  dump_valid    out  1   beat available on dump_addr/dump_data
//  dump_ready    in   1   sink accepts beat when dump_valid & dump_ready
//  dump_addr     out  AW  register index of current beat
//  dump_data     out  DW  register value of current beat
//  dump_last     out  1   marks final beat of the dump
//  dump_is_csum  out  1   beat carries checksum (DUMP_CSUM_EN only; else tied 0)
//  busy          out  1   high from accepted start until done
//  done          out  1   1-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, rf_radd=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0,
//    dump_is_csum=0, busy=0, done=0, csum=0. Reset mid-dump aborts: no done pulse, beats lost.
//  - FSM IDLE -> READ -> SEND -> (READ | CSUM | FIN) -> IDLE.
//  - IDLE: rf_radd=0. start=1 -> READ, idx=0, busy=1 next cycle.
//  - READ (1 cycle): rf_radd=idx; at clock edge register dump_data<=rf_rdata, dump_addr<=idx,
//    dump_last<=(idx==NREGS-1 && no CSUM), dump_valid<=1, csum<=csum^rf_rdata; go SEND.
//  - SEND: hold all dump_* stable while dump_ready=0 (no limit). On valid&ready: dump_valid<=0;
//    idx==NREGS-1 -> FIN (or CSUM); else idx<=idx+1 -> READ.
//  - FIN: done=1 for exactly one cycle, busy<=0, idx<=0 -> IDLE. New start accepted next cycle.
//  - Latency: start cycle N -> first dump_valid at N+2. Throughput: 1 beat / 2 cycles with ready=1.
//  - idx counter is AW bits, never wraps past NREGS-1; no beat emitted for idx>=NREGS.
//  - start while busy: ignored, no restart, no effect on idx/csum.
//  - Values sampled at each READ cycle; register-file writes during a dump are visible for
//    indices not yet read (no freeze). x0 value is whatever the register file returns (expected 0).
// CONFIGURATION
//  DUMP_CSUM_EN defined: after beat NREGS-1 accepted -> CSUM state: one extra beat with
//    dump_data=XOR of all NREGS values, dump_addr=0, dump_is_csum=1, dump_last=1; accepted -> FIN.
//    csum cleared when start accepted. Dump = NREGS+1 beats.
//  DUMP_CSUM_EN undefined: no csum register, dump_is_csum tied 0, dump_last on beat NREGS-1;
//    dump = NREGS beats.
// TESTING (bench instantiates Register + reader, writes via rfwrite/wadd/wdata)
//  1 Reset: rst=1 two cycles -> all outputs 0, busy=0, rf_radd=0.
//  2 Write x2=9, x20=55, then start, dump_ready=1 -> 32 beats addr 0..31, data 9 @2, 55 @20,
//    0 elsewhere; first valid 2 cycles after start; dump_last @31; done 1 cycle later.
//  3 Backpressure: dump_ready=0 for 5 cycles at beat 7 -> beat 7 addr/data stable, no beat 8
//    until accepted; total beats still 32, no dup/skip.
//  4 start pulsed again at beat 4 -> ignored; exactly 32 beats, single done pulse.
//  5 rst=1 while SEND at beat 10 -> next cycle dump_valid=0, busy=0, no done; fresh start dumps
//    addr 0 first.
//  6 DUMP_CSUM_EN, data as test 2 -> 33rd beat dump_is_csum=1, dump_data=32'h0000_003E, dump_last=1.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus valid/ready dump stream used by regfile_dump_reader.
// master = reader side, slave = register file / dump sink side.
interface regfile_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0] rf_radd;
  logic [DW-1:0] rf_rdata;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          dump_is_csum;

  modport master (
    output rf_radd,
    input  rf_rdata,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data,
    output dump_last,
    output dump_is_csum
  );

  modport slave (
    input  rf_radd,
    output rf_rdata,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data,
    input  dump_last,
    input  dump_is_csum
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register file x0..x(NREGS-1) on a start pulse and streams (index, value) beats.
// Define DUMP_CSUM_EN to append a final XOR-checksum beat to every dump.
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  regfile_dump_reader_if.master  dif,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_CSUM = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] radd_q, radd_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept_s;
  logic          at_last_s;

`ifdef DUMP_CSUM_EN
  logic [DW-1:0] csum_q, csum_d;
  logic          is_csum_q, is_csum_d;

  function automatic logic [DW-1:0] csum_fold(input logic [DW-1:0] acc, input logic [DW-1:0] word);
    csum_fold = acc ^ word;
  endfunction
`endif

  assign accept_s  = valid_q & dif.dump_ready;
  assign at_last_s = (idx_q == LAST_IDX);

  // Next-state and next-output computation for the dump walker.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    radd_d  = radd_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DUMP_CSUM_EN
    csum_d    = csum_q;
    is_csum_d = is_csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        radd_d = '0;
        if (start) begin
          state_d = S_READ;
          idx_d   = '0;
          busy_d  = 1'b1;
`ifdef DUMP_CSUM_EN
          csum_d  = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      // rf_radd already equals idx here, so rf_rdata is the value for idx.
      S_READ: begin
        data_d  = dif.rf_rdata;
        addr_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_SEND;
`ifdef DUMP_CSUM_EN
        last_d    = 1'b0;
        csum_d    = csum_fold(csum_q, dif.rf_rdata);
        is_csum_d = 1'b0;
`else
        last_d    = at_last_s;
`endif
      end

      S_SEND: begin
        if (accept_s) begin
          valid_d = 1'b0;
          if (at_last_s) begin
            radd_d = '0;
`ifdef DUMP_CSUM_EN
            state_d = S_CSUM;
`else
            last_d  = 1'b0;
            state_d = S_FIN;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + {{(AW-1){1'b0}}, 1'b1};
            radd_d  = idx_q + {{(AW-1){1'b0}}, 1'b1};
            state_d = S_READ;
          end
        end else begin
          state_d = S_SEND;
        end
      end

`ifdef DUMP_CSUM_EN
      // First cycle loads the checksum beat, then it is held until accepted.
      S_CSUM: begin
        if (!valid_q) begin
          valid_d   = 1'b1;
          data_d    = csum_q;
          addr_d    = '0;
          last_d    = 1'b1;
          is_csum_d = 1'b1;
          state_d   = S_CSUM;
        end else if (dif.dump_ready) begin
          valid_d   = 1'b0;
          last_d    = 1'b0;
          is_csum_d = 1'b0;
          state_d   = S_FIN;
          done_d    = 1'b1;
        end else begin
          state_d   = S_CSUM;
        end
      end
`endif

      S_FIN: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        radd_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        radd_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef DUMP_CSUM_EN
        is_csum_d = 1'b0;
`endif
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      radd_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_CSUM_EN
      csum_q    <= '0;
      is_csum_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      radd_q  <= radd_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DUMP_CSUM_EN
      csum_q    <= csum_d;
      is_csum_q <= is_csum_d;
`endif
    end
  end

  assign dif.rf_radd    = radd_q;
  assign dif.dump_valid = valid_q;
  assign dif.dump_addr  = addr_q;
  assign dif.dump_data  = data_q;
  assign dif.dump_last  = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef DUMP_CSUM_EN
  assign dif.dump_is_csum = is_csum_q;
`else
  assign dif.dump_is_csum = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: a small register-file model feeds regfile_dump_reader; dumps are checked
// against hand-computed vectors (backpressure, ignored restart, reset abort, optional checksum).
module tb_regfile_dump_reader;

`ifdef DUMP_CSUM_EN
  localparam bit CSUM   = 1'b1;
  localparam int NBEATS = 33;
`else
  localparam bit CSUM   = 1'b0;
  localparam int NBEATS = 32;
`endif

  typedef struct {
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    int          stall_beat;
    int          stall_len;
    int          restart_beat;
    logic [31:0] exp_xor;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic busy, done;
  logic rf_we = 1'b0;
  logic [4:0]  rf_wa = 5'd0;
  logic [31:0] rf_wd = 32'd0;
  logic [31:0] mem [32];

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  regfile_dump_reader_if #(.AW(5), .DW(32)) dif ();

  regfile_dump_reader #(.NREGS(32), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dif   (dif),
    .busy  (busy),
    .done  (done)
  );

  // Register file model: x0 hard-wired to zero, combinational read, registered write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (rf_we && rf_wa != 5'd0) begin
      mem[rf_wa] <= rf_wd;
    end
  end

  assign dif.rf_rdata   = (dif.rf_radd == 5'd0) ? 32'd0 : mem[dif.rf_radd];
  assign dif.dump_ready = ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1;
    rf_wa = a;
    rf_wd = d;
    tick();
    rf_we = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input vec_t v, input int i);
    if (i == 0)               exp_word = 32'd0;
    else if (i == int'(v.wa1)) exp_word = v.wd1;
    else if (i == int'(v.wa0)) exp_word = v.wd0;
    else                      exp_word = 32'd0;
  endfunction

  function automatic logic [63:0] beat_pack(input logic [4:0] a, input logic l, input logic c,
                                            input logic [31:0] d);
    beat_pack = {25'd0, a, l, c, d};
  endfunction

  task automatic run_vec(input int vi, input vec_t v);
    int beats = 0;
    int done_cnt = 0;
    int done_c = -1;
    int last_acc_c = -1;
    int first_valid = -1;
    int stall_left = 0;
    bit stall_started = 1'b0;
    bit restarted = 1'b0;
    logic [31:0] xacc = 32'd0;
    logic [63:0] exp_b;

    do_reset();
    rf_write(v.wa0, v.wd0);
    rf_write(v.wa1, v.wd1);
    start = 1'b1;
    tick();
    for (int c = 1; c <= 100; c++) begin
      start = 1'b0;
      if (dif.dump_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cnt++;
        done_c = c;
      end
      if (dif.dump_valid && beats == v.stall_beat && !stall_started) begin
        stall_started = 1'b1;
        stall_left = v.stall_len;
      end
      ready = (stall_left == 0);
      if (beats < 32) exp_b = beat_pack(5'(beats), (beats == 31) && !CSUM, 1'b0, exp_word(v, beats));
      else            exp_b = beat_pack(5'd0, 1'b1, 1'b1, v.exp_xor);
      if (dif.dump_valid && !ready) begin
        chk($sformatf("v%0d stall hold beat %0d", vi, beats),
            beat_pack(dif.dump_addr, dif.dump_last, dif.dump_is_csum, dif.dump_data), exp_b);
        stall_left--;
      end
      if (dif.dump_valid && beats == v.restart_beat && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (dif.dump_valid && ready) begin
        if (beats < NBEATS)
          chk($sformatf("v%0d beat %0d", vi, beats),
              beat_pack(dif.dump_addr, dif.dump_last, dif.dump_is_csum, dif.dump_data), exp_b);
        if (beats < 32) xacc = xacc ^ dif.dump_data;
        beats++;
        last_acc_c = c;
      end
      tick();
    end
    start = 1'b0;
    ready = 1'b1;
    chk($sformatf("v%0d beat count", vi), 64'(beats), 64'(NBEATS));
    chk($sformatf("v%0d first valid latency", vi), 64'(first_valid), 64'd2);
    chk($sformatf("v%0d done pulses", vi), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d done timing", vi), 64'(done_c), 64'(last_acc_c + 1));
    chk($sformatf("v%0d data xor", vi), 64'(xacc), 64'(v.exp_xor));
    chk($sformatf("v%0d busy after done", vi), 64'(busy), 64'd0);
  endtask

  initial begin
    bit found;
    int done_seen;
    int valid_seen;

    vecs[0] = '{5'd2, 32'd9,          5'd20, 32'd55,          -1, 0, -1, 32'h0000_003E};
    vecs[1] = '{5'd2, 32'd9,          5'd20, 32'd55,           7, 5, -1, 32'h0000_003E};
    vecs[2] = '{5'd2, 32'd9,          5'd20, 32'd55,          -1, 0,  4, 32'h0000_003E};
    vecs[3] = '{5'd5, 32'hDEAD_BEEF,  5'd31, 32'h1234_5678,   31, 3,  0, 32'hCC99_E897};
    vecs[4] = '{5'd1, 32'h0000_0001,  5'd31, 32'h8000_0000,    0, 2, 30, 32'h8000_0001};

    // Reset state.
    do_reset();
    chk("reset dump_valid",   64'(dif.dump_valid),   64'd0);
    chk("reset dump_addr",    64'(dif.dump_addr),    64'd0);
    chk("reset dump_data",    64'(dif.dump_data),    64'd0);
    chk("reset dump_last",    64'(dif.dump_last),    64'd0);
    chk("reset dump_is_csum", 64'(dif.dump_is_csum), 64'd0);
    chk("reset rf_radd",      64'(dif.rf_radd),      64'd0);
    chk("reset busy",         64'(busy),             64'd0);
    chk("reset done",         64'(done),             64'd0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset while beat 10 is waiting in SEND aborts the dump.
    do_reset();
    rf_write(5'd2, 32'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (dif.dump_valid && dif.dump_addr == 5'd10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort reached beat 10", 64'(found), 64'd1);
    ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    chk("abort dump_valid", 64'(dif.dump_valid), 64'd0);
    chk("abort busy",       64'(busy),           64'd0);
    chk("abort done",       64'(done),           64'd0);
    done_seen = 0;
    valid_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen++;
      if (dif.dump_valid) valid_seen++;
      tick();
    end
    chk("abort no done later",  64'(done_seen),  64'd0);
    chk("abort no beats later", 64'(valid_seen), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart busy", 64'(busy), 64'd1);
    tick();
    chk("restart first beat",
        beat_pack(dif.dump_addr, dif.dump_last, dif.dump_is_csum, {31'd0, dif.dump_valid}),
        beat_pack(5'd0, 1'b0, 1'b0, 32'd1));
    chk("restart first data", 64'(dif.dump_data), 64'd0);
    tick();
    tick();
    chk("restart second beat addr", 64'(dif.dump_addr), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
